// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder sequencer: adds two WIDTH-bit operands one bit per clock,
// LSB first, through a single full-adder slice with a registered carry.
// A start/done handshake frames each operation. The FSM moves
// IDLE -> ADD (WIDTH cycles) -> DONE (one cycle) -> IDLE.
// All outputs come straight from flops.

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Bit counter width: it must hold 0..WIDTH-1.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Full-adder sum bit.
   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   // Full-adder carry: the majority of the three inputs.
   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opa_s;
   logic [WIDTH-1:0] opb_r;
   logic [WIDTH-1:0] opb_s;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] sum_s;
   logic             carry_r;
   logic             carry_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_s;
   logic             cout_r;
   logic             cout_s;
   logic             busy_r;
   logic             done_r;
   logic             bit_sum_s;
   logic             bit_carry_s;
   logic             last_bit_s;

   // The single full-adder slice works on the operand LSBs and the carry flop.
   always_comb begin
      bit_sum_s   = fa_sum(opa_r[0], opb_r[0], carry_r);
      bit_carry_s = fa_carry(opa_r[0], opb_r[0], carry_r);
      last_bit_s  = (cnt_r == CNT_LAST);
   end

   // Next-state logic. In IDLE, start is honoured. In ADD and DONE it is ignored.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_ADD;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ADD: begin
            if (last_bit_s) begin
               state_s = S_DONE;
            end else begin
               state_s = S_ADD;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Datapath next values: capture operands on accept and shift one bit per ADD cycle.
   // sum keeps its old value until the shifting starts.
   always_comb begin
      opa_s   = opa_r;
      opb_s   = opb_r;
      sum_s   = sum_r;
      carry_s = carry_r;
      cnt_s   = cnt_r;
      cout_s  = cout_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               opa_s   = a;
               opb_s   = b;
               carry_s = cin;
               cnt_s   = {CW{1'b0}};
            end else begin
               opa_s   = opa_r;
               opb_s   = opb_r;
            end
         end
         S_ADD: begin
            opa_s   = {1'b0, opa_r[WIDTH-1:1]};
            opb_s   = {1'b0, opb_r[WIDTH-1:1]};
            sum_s   = {bit_sum_s, sum_r[WIDTH-1:1]};
            carry_s = bit_carry_s;
            cnt_s   = cnt_r + CW'(1);
            if (last_bit_s) begin
               // cout changes only on the edge that enters DONE.
               cout_s = bit_carry_s;
            end else begin
               cout_s = cout_r;
            end
         end
         S_DONE: begin
            cnt_s = cnt_r;
         end
         default: begin
            cnt_s = {CW{1'b0}};
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath registers. Reset clears them, which also aborts an operation in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         opa_r   <= {WIDTH{1'b0}};
         opb_r   <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         cout_r  <= 1'b0;
      end else begin
         opa_r   <= opa_s;
         opb_r   <= opb_s;
         sum_r   <= sum_s;
         carry_r <= carry_s;
         cnt_r   <= cnt_s;
         cout_r  <= cout_s;
      end
   end

   // Status flags, registered from the next state so they line up with state_r.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s != S_IDLE);
         done_r <= (state_s == S_DONE);
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed-vector bench for serial_add_ctrl at WIDTH=8. The expected values
// are worked out by hand from {cout,sum} = a + b + cin.

module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int total;
   int bad;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for the edge after the current one, then lets outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one add: accept, then wait for done with a bound, then check the result.
   task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] es, input logic ec);
      int n;
      @(negedge clk);
      a = va; b = vb; cin = vc; start = 1'b1;
      tick();                       // accept edge E0
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      n = 0;
      while (n < 20 && done !== 1'b1) begin
         tick();
         n++;
      end
      // done is high after edge E_WIDTH, which is WIDTH+1 edges counting E0.
      chk({tag, "_lat"}, 32'(n), 32'(W));
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      tick();
      chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
      chk({tag, "_hold"}, 32'({cout, sum}), 32'({ec, es}));
   endtask

   // Directed test sequence.
   initial begin
      logic [7:0] pa [0:3];
      logic [7:0] pb [0:3];
      logic       pc [0:3];
      logic [7:0] ps [0:3];
      logic       pco [0:3];
      int         n;
      int         dones;
      int         k;
      int         last;
      int         cyc;

      pa[0] = 8'h12; pb[0] = 8'h34; pc[0] = 1'b0; ps[0] = 8'h46; pco[0] = 1'b0;
      pa[1] = 8'h80; pb[1] = 8'h80; pc[1] = 1'b1; ps[1] = 8'h01; pco[1] = 1'b1;
      pa[2] = 8'hF0; pb[2] = 8'h0F; pc[2] = 1'b1; ps[2] = 8'h00; pco[2] = 1'b1;
      pa[3] = 8'h01; pb[3] = 8'h01; pc[3] = 1'b0; ps[3] = 8'h02; pco[3] = 1'b0;

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      cin   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset", {21'd0, busy, done, cout, sum}, 32'd0);

      // Tests 1-3: basic add, a full carry ripple, and checks for a stale carry.
      run_add("t1", 8'h2B, 8'h1C, 1'b0, 8'h47, 1'b0);
      run_add("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_add("t3a", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      run_add("t3b", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

      // Test 4: start pulses during ADD/DONE, with new operands, are ignored.
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      tick();
      a = 8'hAA; b = 8'h55; cin = 1'b1;
      n = 0;
      while (n < 20 && done !== 1'b1) begin
         start = ~start;
         tick();
         n++;
      end
      start = 1'b1;                 // still DONE here, so this is ignored
      chk("t4_lat", 32'(n), 32'(W));
      chk("t4_sum", 32'({cout, sum}), 32'h030);
      tick();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dones++;
      end
      chk("t4_nodone", 32'(dones), 32'd0);
      chk("t4_idle", 32'(busy), 32'd0);
      chk("t4_keep", 32'(sum), 32'h30);

      // Test 5: reset during the 4th ADD cycle aborts the operation.
      @(negedge clk);
      a = 8'h55; b = 8'h0F; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      // Three sum bits (0,0,1) have shifted in above the old 0x30 >> 3.
      chk("t5_partial", 32'(sum), 32'h86);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_abort", {21'd0, busy, done, cout, sum}, 32'd0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dones++;
      end
      chk("t5_nodone", 32'(dones), 32'd0);
      run_add("t5b", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

      // Test 6: start held high, so operations run back to back every 10 cycles.
      @(negedge clk);
      a = pa[0]; b = pb[0]; cin = pc[0]; start = 1'b1;
      k = 0;
      last = -1;
      cyc = 0;
      while (cyc < 40 && k < 3) begin
         tick();
         if (cyc % 10 == 0) begin
            a = pa[cyc/10 + 1]; b = pb[cyc/10 + 1]; cin = pc[cyc/10 + 1];
         end
         if (done) begin
            chk("t6_sum", 32'({cout, sum}), 32'({pco[k], ps[k]}));
            if (last >= 0) chk("t6_gap", 32'(cyc - last), 32'd10);
            last = cyc;
            k++;
            if (k == 3) start = 1'b0;
         end
         cyc++;
      end
      chk("t6_count", 32'(k), 32'd3);
      tick();
      tick();
      tick();
      chk("t6_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
